cpu_bus_seq: RTL

- T-cycle sequencer and external bus interface between the CPU core and the system memory bus.
- Divides each M-cycle into four T-states (T1..T4).
- Latches the core's per-M-cycle address, read/write request and write data.
- Drives the external strobes and returns captured read data to the core's `din`.
- Arbitrates the external bus for a DMA/hold requester at M-cycle boundaries.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/cpu_bus_seq_if.sv | 36 +++
 rtl/tcyc_counter.sv | 37 +++
 rtl/cpu_bus_seq.sv | 118 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU bus sequencer.
//   bus_op_t : kind of access latched for the current M-cycle
//   T1..T4   : T-state encodings as seen on tstate
//   T_PER_M  : T-states per M-cycle
package cpu_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_READ  = 2'd1,
    BUS_WRITE = 2'd2
  } bus_op_t;

  localparam logic [1:0] T1 = 2'd0;
  localparam logic [1:0] T2 = 2'd1;
  localparam logic [1:0] T3 = 2'd2;
  localparam logic [1:0] T4 = 2'd3;

  localparam int unsigned T_PER_M = 4;

endpackage

// File: rtl/cpu_bus_seq_if.sv
// Core-side and external-side signals of the bus sequencer.
//   master : view used by the sequencer (drives core_din, status and external strobes)
//   slave  : view used by the surroundings (core plus memory/DMA side)
interface cpu_bus_seq_if;

  logic [15:0] core_adr;
  logic        core_rd;
  logic        core_wr;
  logic        core_m1;
  logic [7:0]  core_dout;
  logic [7:0]  core_din;
  logic [1:0]  tstate;
  logic        mcyc_end;
  logic        stall;
  logic [15:0] ext_adr;
  logic [7:0]  ext_dout;
  logic [7:0]  ext_din;
  logic        ext_rd;
  logic        ext_wr;
  logic        ext_m1;
  logic        ext_hold;
  logic        ext_hlda;

  modport master (
    input  core_adr, core_rd, core_wr, core_m1, core_dout, ext_din, ext_hold,
    output core_din, tstate, mcyc_end, stall, ext_adr, ext_dout, ext_rd, ext_wr, ext_m1,
           ext_hlda
  );

  modport slave (
    output core_adr, core_rd, core_wr, core_m1, core_dout, ext_din, ext_hold,
    input  core_din, tstate, mcyc_end, stall, ext_adr, ext_dout, ext_rd, ext_wr, ext_m1,
           ext_hlda
  );

endinterface

// File: rtl/tcyc_counter.sv
// T-state counter: 2-bit, advances on each enabled clock edge, wraps T4 -> T1.
//   clk      : system clock
//   reset_n  : synchronous active-low reset (forces T1)
//   cen      : advance enable
//   tstate   : current T-state, 0=T1 .. 3=T4
//   mcyc_end : high during T4
module tcyc_counter
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cen,
  output logic [1:0] tstate,
  output logic       mcyc_end
);

  logic [1:0] tstate_q, tstate_d;

  always_comb begin
    tstate_d = tstate_q;
    if (cen) begin
      tstate_d = tstate_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tstate_q <= T1;
    end else begin
      tstate_q <= tstate_d;
    end
  end

  assign tstate   = tstate_q;
  assign mcyc_end = (tstate_q == 2'(T_PER_M - 1));

endmodule

// File: rtl/cpu_bus_seq.sv
// T-cycle sequencer and external bus interface between the CPU core and the memory bus.
//   clk     : system clock
//   reset_n : synchronous active-low reset, independent of cen
//   cen     : clock enable; all state holds while low
//   bus     : core request/response, T-state status and external bus signals
// Each M-cycle is T1..T4. At the M-cycle start (edge ending T4, or the first enabled edge
// after reset) either the bus is granted to the hold requester for one whole M-cycle, or
// the core request is latched and decoded into strobes per T-state.
module cpu_bus_seq
  import cpu_pkg::*;
#(
  parameter int unsigned RD_SAMPLE_T = 3,
  parameter int unsigned WR_FIRST_T  = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cen,
  cpu_bus_seq_if.master bus
);

  // tstate encodings of the last read-strobe T-state and the first write-strobe T-state
  localparam logic [1:0] RdLastT  = 2'(RD_SAMPLE_T - 1);
  localparam logic [1:0] WrFirstT = 2'(WR_FIRST_T - 1);

  logic        first_q, first_d;
  bus_op_t     op_q, op_d;
  logic        grant_q, grant_d;
  logic [15:0] adr_q, adr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        m1_q, m1_d;
  logic [7:0]  din_q, din_d;

  logic [1:0]  tstate;
  logic        mcyc_end;
  logic        mcyc_start;

  // The first enabled edge after reset opens T1 of the first M-cycle, so the counter
  // stays at T1 across it instead of advancing.
  tcyc_counter u_tcyc (
    .clk      (clk),
    .reset_n  (reset_n),
    .cen      (cen & ~first_q),
    .tstate   (tstate),
    .mcyc_end (mcyc_end)
  );

  assign mcyc_start = cen & (first_q | mcyc_end);

  always_comb begin
    first_d = first_q & ~cen;
    op_d    = op_q;
    grant_d = grant_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    m1_d    = m1_q;
    din_d   = din_q;

    // Uses the op of the cycle being finished, so a T4 sample point still works.
    if (cen && op_q == BUS_READ && tstate == RdLastT) begin
      din_d = bus.ext_din;
    end

    if (mcyc_start) begin
      if (bus.ext_hold) begin
        // Core request is left untouched on its inputs and picked up after release.
        grant_d = 1'b1;
        op_d    = BUS_IDLE;
        adr_d   = '0;
        wdata_d = '0;
        m1_d    = 1'b0;
      end else begin
        grant_d = 1'b0;
        adr_d   = bus.core_adr;
        wdata_d = bus.core_dout;
        m1_d    = bus.core_m1;
        if (bus.core_wr) begin
          op_d = BUS_WRITE;
        end else if (bus.core_rd) begin
          op_d = BUS_READ;
        end else begin
          op_d = BUS_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      first_q <= 1'b1;
      op_q    <= BUS_IDLE;
      grant_q <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      m1_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      first_q <= first_d;
      op_q    <= op_d;
      grant_q <= grant_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      m1_q    <= m1_d;
      din_q   <= din_d;
    end
  end

  assign bus.tstate   = tstate;
  assign bus.mcyc_end = mcyc_end;
  assign bus.stall    = grant_q;
  assign bus.ext_hlda = grant_q;
  assign bus.ext_adr  = adr_q;
  assign bus.ext_dout = wdata_q;
  assign bus.core_din = din_q;
  assign bus.ext_rd   = (op_q == BUS_READ) && (tstate <= RdLastT);
  assign bus.ext_wr   = (op_q == BUS_WRITE) && (tstate >= WrFirstT) && (tstate <= T3);
  assign bus.ext_m1   = (op_q == BUS_READ) && m1_q;

endmodule
